// File: rtl/ntt_stage_seq.sv
// Address sequencer for one radix-2 Cooley-Tukey NTT stage, with in-place write-back
// delayed to match the butterfly latency and a per-pass sticky error flag.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing one butterfly per non-held cycle
//   DRAIN | issue finished, waiting for in-flight write-backs
module ntt_stage_seq #(
  parameter int LOG_N  = 4,
  parameter int WIDTH  = 64,
  parameter int BF_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LOG_N-1:0]   stage,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               rd_en,
  output logic [LOG_N-1:0]   rd_addr_a,
  output logic [LOG_N-1:0]   rd_addr_b,
  output logic [LOG_N-2:0]   tw_addr,
  input  logic [WIDTH-1:0]   bf_out_a,
  input  logic [WIDTH-1:0]   bf_out_b,
  input  logic               bf_err,
  output logic               wr_en,
  output logic [LOG_N-1:0]   wr_addr_a,
  output logic [LOG_N-1:0]   wr_addr_b,
  output logic [WIDTH-1:0]   wr_data_a,
  output logic [WIDTH-1:0]   wr_data_b,
  output logic               err_sticky
);

  localparam int NBF   = 1 << (LOG_N - 1);
  localparam int DEPTH = 1 + BF_LAT;
  localparam logic [LOG_N-2:0] K_LAST    = (LOG_N-1)'(NBF - 1);
  localparam logic [LOG_N:0]   STAGE_LIM = (LOG_N+1)'(LOG_N);
  localparam logic [LOG_N-1:0] SH_TOP    = LOG_N'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [LOG_N-1:0] s_q;
  logic [LOG_N-2:0] k;

  logic             issue;
  logic [LOG_N-1:0] k_ext;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] mask;
  logic [LOG_N-1:0] j;
  logic [LOG_N-2:0] j_tw;
  logic [LOG_N-1:0] addr_a;

  logic [DEPTH-1:0] pv;
  logic [LOG_N-1:0] pa [DEPTH];
  logic [LOG_N-1:0] pb [DEPTH];

  // Issue is combinational on hold so a held cycle never strobes the RAM.
  always_comb begin
    issue  = (state == RUN) && !hold;
    k_ext  = {1'b0, k};
    half   = LOG_N'(1) << s_q;
    mask   = half - LOG_N'(1);
    j      = k_ext & mask;
    j_tw   = k & mask[LOG_N-2:0];
    addr_a = ((k_ext >> s_q) << (s_q + 1'b1)) | j;
    rd_en     = issue;
    rd_addr_a = issue ? addr_a : '0;
    rd_addr_b = issue ? (addr_a | half) : '0;
    tw_addr   = issue ? (j_tw << (SH_TOP - s_q)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv    <= {pv[DEPTH-2:0], issue};
      pa[0] <= rd_addr_a;
      pb[0] <= rd_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign wr_en     = pv[DEPTH-1];
  assign wr_addr_a = pa[DEPTH-1];
  assign wr_addr_b = pb[DEPTH-1];
  assign wr_data_a = bf_out_a;
  assign wr_data_b = bf_out_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_q        <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (wr_en) err_sticky <= err_sticky | bf_err;
      unique case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, stage} < STAGE_LIM) begin
              s_q        <= stage;
              k          <= '0;
              err_sticky <= 1'b0;
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!hold) begin
            if (k == K_LAST) state <= DRAIN;
            else             k     <= k + 1'b1;
          end
        end
        DRAIN: begin
          // Leave once only the oldest entry (being written this cycle) can be valid.
          if (pv[DEPTH-2:0] == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Directed bench for ntt_stage_seq: address patterns per stage, hold, config error,
// ignored start, sticky error and mid-pass reset, against hand-computed tables.
module tb_ntt_stage_seq;
  localparam int LOG_N = 4;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LOG_N-1:0] stage;
  logic             hold;
  logic             busy, done, cfg_err, rd_en, wr_en, err_sticky;
  logic [LOG_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG_N-2:0] tw_addr;
  logic [WIDTH-1:0] bf_out_a, bf_out_b, wr_data_a, wr_data_b;
  logic             bf_err;

  ntt_stage_seq #(.LOG_N(LOG_N), .WIDTH(WIDTH), .BF_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .hold(hold),
    .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_out_a(bf_out_a), .bf_out_b(bf_out_b), .bf_err(bf_err),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  tab_a  [4][8];
  logic [3:0]  tab_b  [4][8];
  logic [2:0]  tab_tw [4][8];

  logic        obs_rd [40], obs_wr [40], obs_busy [40], obs_done [40], obs_cfg [40], obs_err [40];
  logic [3:0]  obs_a  [40], obs_b [40], obs_wa [40], obs_wb [40];
  logic [2:0]  obs_tw [40];
  logic [63:0] obs_wda [40], obs_wdb [40];

  // Start in cycle 0, then sample cycles 1..ncyc at the falling edge.
  task automatic run_pass(input logic [3:0] s, input int hs, input int hl, input int inj_c,
                          input int err_c1, input int err_c2, input int ncyc);
    @(posedge clk); #1;
    start = 1'b1; stage = s; hold = 1'b0; bf_err = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start    = (c == inj_c);
      if (c == inj_c) stage = 4'd0;
      hold     = (hl > 0) && (c >= hs) && (c < hs + hl);
      bf_err   = (c == err_c1) || (c == err_c2);
      bf_out_a = 64'h1111_0000_0000_0000 | 64'(c);
      bf_out_b = 64'h2222_0000_0000_0000 | 64'(c);
      @(negedge clk);
      obs_rd[c] = rd_en;   obs_a[c] = rd_addr_a; obs_b[c] = rd_addr_b; obs_tw[c] = tw_addr;
      obs_wr[c] = wr_en;   obs_wa[c] = wr_addr_a; obs_wb[c] = wr_addr_b;
      obs_wda[c] = wr_data_a; obs_wdb[c] = wr_data_b;
      obs_busy[c] = busy;  obs_done[c] = done; obs_cfg[c] = cfg_err; obs_err[c] = err_sticky;
    end
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0; bf_err = 1'b0;
  endtask

  // Runs a pass and checks every sampled cycle against the expected issue schedule.
  task automatic test_pass(input int s, input int hs, input int hl, input int inj_c, input string tag);
    int exp_k [40];
    int kk, last, wk;
    kk = 0; last = 0;
    for (int c = 0; c < 40; c++) exp_k[c] = -1;
    for (int c = 1; c < 40 && kk < 8; c++) begin
      if (!(hl > 0 && c >= hs && c < hs + hl)) begin
        exp_k[c] = kk; kk++; last = c;
      end
    end
    run_pass(4'(s), hs, hl, inj_c, -1, -1, last + 7);
    for (int c = 1; c <= last + 7; c++) begin
      n_checks++;
      if (obs_rd[c] !== (exp_k[c] >= 0)) begin
        n_fail++; $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, obs_rd[c], exp_k[c] >= 0);
      end
      if (exp_k[c] >= 0) begin
        n_checks++;
        if (obs_a[c] !== tab_a[s][exp_k[c]] || obs_b[c] !== tab_b[s][exp_k[c]] || obs_tw[c] !== tab_tw[s][exp_k[c]]) begin
          n_fail++;
          $display("FAIL %s rd_addr c=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d", tag, c,
                   obs_a[c], obs_b[c], obs_tw[c], tab_a[s][exp_k[c]], tab_b[s][exp_k[c]], tab_tw[s][exp_k[c]]);
        end
      end
      wk = (c >= 5) ? exp_k[c-4] : -1;
      n_checks++;
      if (obs_wr[c] !== (wk >= 0)) begin
        n_fail++; $display("FAIL %s wr_en c=%0d got %b want %b", tag, c, obs_wr[c], wk >= 0);
      end
      if (wk >= 0) begin
        n_checks++;
        if (obs_wa[c] !== tab_a[s][wk] || obs_wb[c] !== tab_b[s][wk]) begin
          n_fail++;
          $display("FAIL %s wr_addr c=%0d got a=%0d b=%0d want a=%0d b=%0d", tag, c,
                   obs_wa[c], obs_wb[c], tab_a[s][wk], tab_b[s][wk]);
        end
      end
      n_checks++;
      if (obs_done[c] !== (c == last + 5) || obs_busy[c] !== (c < last + 5)) begin
        n_fail++;
        $display("FAIL %s done/busy c=%0d got %b/%b want %b/%b", tag, c, obs_done[c], obs_busy[c],
                 c == last + 5, c < last + 5);
      end
      n_checks++;
      if (obs_wda[c] !== (64'h1111_0000_0000_0000 | 64'(c)) || obs_wdb[c] !== (64'h2222_0000_0000_0000 | 64'(c))) begin
        n_fail++; $display("FAIL %s wr_data c=%0d got %h %h", tag, c, obs_wda[c], obs_wdb[c]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, cfg_err, rd_en, wr_en, err_sticky} !== 6'b0 ||
        {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 19'b0) begin
      n_fail++; $display("FAIL reset_state got flags=%b addrs=%h want 0", {busy, done, cfg_err, rd_en, wr_en, err_sticky},
                         {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stage0();   test_pass(0, 0, 0, -1, "stage0");      endtask
  task automatic test_stage3();   test_pass(3, 0, 0, -1, "stage3");      endtask
  task automatic test_stage1();   test_pass(1, 0, 0, -1, "stage1");      endtask
  task automatic test_hold();     test_pass(3, 3, 3, -1, "hold");        endtask
  task automatic test_start_busy(); test_pass(3, 0, 0, 4, "start_busy"); endtask

  task automatic test_cfg_err();
    run_pass(4'd4, 0, 0, -1, -1, -1, 4);
    n_checks++;
    if (obs_cfg[1] !== 1'b1 || obs_cfg[2] !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err pulse got %b%b want 10", obs_cfg[1], obs_cfg[2]);
    end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (obs_busy[c] !== 1'b0 || obs_rd[c] !== 1'b0 || obs_done[c] !== 1'b0) begin
        n_fail++; $display("FAIL cfg_err_idle c=%0d got busy=%b rd=%b done=%b want 000", c, obs_busy[c], obs_rd[c], obs_done[c]);
      end
    end
  endtask

  task automatic test_err_sticky();
    // bf_err at c=3 has no write; at c=7 it coincides with a write.
    run_pass(4'd2, 0, 0, -1, 3, 7, 15);
    n_checks++;
    if (obs_err[4] !== 1'b0 || obs_err[7] !== 1'b0) begin
      n_fail++; $display("FAIL err_no_write got %b%b want 00", obs_err[4], obs_err[7]);
    end
    n_checks++;
    if (obs_err[8] !== 1'b1 || obs_err[15] !== 1'b1) begin
      n_fail++; $display("FAIL err_set got %b%b want 11", obs_err[8], obs_err[15]);
    end
    run_pass(4'd0, 0, 0, -1, -1, -1, 14);
    n_checks++;
    if (obs_err[1] !== 1'b0 || obs_err[14] !== 1'b0) begin
      n_fail++; $display("FAIL err_clear got %b%b want 00", obs_err[1], obs_err[14]);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; stage = 4'd3;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got wr_en=%b busy=%b want 1 1", wr_en, busy);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, cfg_err, rd_en, wr_en, err_sticky} !== 6'b0 ||
        {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 19'b0) begin
      n_fail++; $display("FAIL async_reset got flags=%b addrs=%h want 0", {busy, done, cfg_err, rd_en, wr_en, err_sticky},
                         {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++; $display("FAIL post_reset c=%0d got wr=%b busy=%b rd=%b want 000", c, wr_en, busy, rd_en);
      end
    end
    test_pass(2, 0, 0, -1, "after_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stage = '0; hold = 1'b0; bf_err = 1'b0;
    bf_out_a = '0; bf_out_b = '0;
    tab_a[0]  = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
    tab_b[0]  = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
    tab_tw[0] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    tab_a[1]  = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13};
    tab_b[1]  = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11, 4'd14, 4'd15};
    tab_tw[1] = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4};
    tab_a[2]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
    tab_b[2]  = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15};
    tab_tw[2] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6};
    tab_a[3]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    tab_b[3]  = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    tab_tw[3] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    test_reset();
    test_stage0();
    test_stage3();
    test_stage1();
    test_hold();
    test_cfg_err();
    test_start_busy();
    test_err_sticky();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
